// File: rtl/ir_queue_pkg.sv
// Shared CPU constants: instruction width, the NOP encoding, decode field positions
// and the queue operation kind.
package ir_queue_pkg;

  localparam int INSTR_W = 32;

  // MIPS sll $0,$0,0 encodes as all zeros and is the canonical NOP.
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } q_op_e;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INSTR_W-1:0] ir);
    return ir[OPC_MSB:OPC_LSB];
  endfunction

  function automatic logic [FUNCT_MSB-FUNCT_LSB:0] funct_of(input logic [INSTR_W-1:0] ir);
    return ir[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/ir_queue_if.sv
// Fetch/decode handshake bundle around the instruction queue.
// The master side is the pipeline (fetch + decode + redirect); the slave is the queue.
interface ir_queue_if
  import ir_queue_pkg::*;
#(
  parameter int DW    = INSTR_W,
  parameter int PCW   = 32,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [DW-1:0]  in_ir;
  logic [PCW-1:0] in_pc;
  logic           out_valid;
  logic           out_ready;
  logic [DW-1:0]  out_ir;
  logic [PCW-1:0] out_pc;
  logic [CW-1:0]  count;

  modport master (
    output flush, in_valid, in_ir, in_pc, out_ready,
    input  in_ready, out_valid, out_ir, out_pc, count
  );

  modport slave (
    input  flush, in_valid, in_ir, in_pc, out_ready,
    output in_ready, out_valid, out_ir, out_pc, count
  );

endinterface

// File: rtl/ir_queue.sv
// Instruction-register queue between fetch and decode: DEPTH-entry FIFO of {ir, pc}
// with valid/ready on both sides, synchronous flush for redirects and NOP when empty.
module ir_queue
  import ir_queue_pkg::*;
#(
  parameter int DW    = INSTR_W,
  parameter int PCW   = 32,
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  ir_queue_if.slave q
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("ir_queue: DEPTH must be a power of two and >= 2");
  end

  logic [DW-1:0]  mem_ir [DEPTH];
  logic [PCW-1:0] mem_pc [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic  full;
  logic  empty;
  logic  push;
  logic  pop;
  q_op_e op;

  // Full/empty come from the registered count only, so in_ready never sees out_ready.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = q.in_valid & ~full;
  assign pop   = q.out_ready & ~empty;
  assign op    = q_op_e'({push, pop});

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      unique case (op)
        OP_PUSH: begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          count_d  = count_q + CW'(1);
        end
        OP_POP: begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          count_d  = count_q - CW'(1);
        end
        OP_BOTH: begin
          wr_ptr_d = wr_ptr_q + PW'(1);
          rd_ptr_d = rd_ptr_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is never cleared; stale entries are hidden by the empty mask below.
  always_ff @(posedge clk) begin
    if (!rst && !q.flush && push) begin
      mem_ir[wr_ptr_q] <= q.in_ir;
      mem_pc[wr_ptr_q] <= q.in_pc;
    end
  end

  assign q.in_ready  = ~full;
  assign q.out_valid = ~empty;
  assign q.out_ir    = empty ? DW'(NOP_INSTR) : mem_ir[rd_ptr_q];
  assign q.out_pc    = empty ? '0 : mem_pc[rd_ptr_q];
  assign q.count     = count_q;

endmodule

// File: tb/tb_ir_queue.sv
// Directed bench for ir_queue: a vector table for reset/fill/drain/full cases and
// hand-written sequences for streaming, flush and reset-during-traffic.
module tb_ir_queue;
  import ir_queue_pkg::*;

  localparam int DW    = 32;
  localparam int PCW   = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic clk;
  logic rst;

  ir_queue_if #(.DW(DW), .PCW(PCW), .DEPTH(DEPTH)) qif ();

  ir_queue #(.DW(DW), .PCW(PCW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each row: inputs held across one rising edge, then outputs expected after it.
  typedef struct {
    string          name;
    logic           rst;
    logic           flush;
    logic           in_valid;
    logic [DW-1:0]  in_ir;
    logic [PCW-1:0] in_pc;
    logic           out_ready;
    logic           e_out_valid;
    logic           e_in_ready;
    logic [CW-1:0]  e_count;
    logic [DW-1:0]  e_out_ir;
    logic [PCW-1:0] e_out_pc;
  } vec_t;

  vec_t vecs[$];
  int   checks;
  int   errors;

  task automatic add(input string nm, input logic r, input logic f, input logic iv,
                     input logic [DW-1:0] ir, input logic [PCW-1:0] pc, input logic ordy,
                     input logic eov, input logic eir, input int ecnt,
                     input logic [DW-1:0] eoir, input logic [PCW-1:0] eopc);
    vec_t v;
    v.name = nm; v.rst = r; v.flush = f; v.in_valid = iv; v.in_ir = ir; v.in_pc = pc;
    v.out_ready = ordy; v.e_out_valid = eov; v.e_in_ready = eir; v.e_count = CW'(ecnt);
    v.e_out_ir = eoir; v.e_out_pc = eopc;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic f, input logic iv,
                       input logic [DW-1:0] ir, input logic [PCW-1:0] pc, input logic ordy);
    rst           = r;
    qif.flush     = f;
    qif.in_valid  = iv;
    qif.in_ir     = ir;
    qif.in_pc     = pc;
    qif.out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string nm, input logic eov, input logic eir,
                              input int ecnt, input logic [DW-1:0] eoir,
                              input logic [PCW-1:0] eopc);
    logic ok;
    checks++;
    ok = (qif.out_valid === eov) && (qif.in_ready === eir) && (qif.count === CW'(ecnt)) &&
         (qif.out_ir === eoir) && (qif.out_pc === eopc);
    if (!ok) begin
      errors++;
      $display("FAIL %s: got valid=%b ready=%b count=%0d ir=%h pc=%h, want valid=%b ready=%b count=%0d ir=%h pc=%h",
               nm, qif.out_valid, qif.in_ready, qif.count, qif.out_ir, qif.out_pc,
               eov, eir, ecnt, eoir, eopc);
    end else begin
      $display("ok   %s: valid=%b ready=%b count=%0d ir=%h pc=%h",
               nm, qif.out_valid, qif.in_ready, qif.count, qif.out_ir, qif.out_pc);
    end
  endtask

  localparam logic [DW-1:0] W_A = 32'h2008_0005;
  localparam logic [DW-1:0] W_B = 32'h0109_5020;
  localparam logic [DW-1:0] W_C = 32'h1111_1111;
  localparam logic [DW-1:0] W_D = 32'h2222_2222;
  localparam logic [DW-1:0] W_E = 32'h3333_3333;

  initial begin
    checks = 0;
    errors = 0;
    drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);

    //   name          rst f  iv  ir     pc      ordy  ov rdy cnt out_ir  out_pc
    add("rst0",        1, 0, 0, '0,    '0,      0,    0, 1,  0,  '0,     '0);
    add("rst1",        1, 0, 0, '0,    '0,      0,    0, 1,  0,  '0,     '0);
    add("idle",        0, 0, 0, '0,    '0,      0,    0, 1,  0,  '0,     '0);
    add("push_a",      0, 0, 1, W_A,   32'h0,   0,    1, 1,  1,  W_A,    32'h0);
    add("push_b",      0, 0, 1, W_B,   32'h4,   0,    1, 1,  2,  W_A,    32'h0);
    add("stall_hold",  0, 0, 0, '0,    '0,      0,    1, 1,  2,  W_A,    32'h0);
    add("push_c",      0, 0, 1, W_C,   32'h8,   0,    1, 1,  3,  W_A,    32'h0);
    add("push_d_full", 0, 0, 1, W_D,   32'hC,   0,    1, 0,  4,  W_A,    32'h0);
    add("push_e_drop", 0, 0, 1, W_E,   32'h10,  0,    1, 0,  4,  W_A,    32'h0);
    add("pop_a",       0, 0, 0, '0,    '0,      1,    1, 1,  3,  W_B,    32'h4);
    add("pop_b",       0, 0, 0, '0,    '0,      1,    1, 1,  2,  W_C,    32'h8);
    add("pop_c",       0, 0, 0, '0,    '0,      1,    1, 1,  1,  W_D,    32'hC);
    add("pop_d_empty", 0, 0, 0, '0,    '0,      1,    0, 1,  0,  '0,     '0);
    add("pop_on_empty",0, 0, 0, '0,    '0,      1,    0, 1,  0,  '0,     '0);
    // Full with in_valid & out_ready: only the pop happens.
    add("fill0",       0, 0, 1, 32'hF0,32'h20,  0,    1, 1,  1,  32'hF0, 32'h20);
    add("fill1",       0, 0, 1, 32'hF1,32'h24,  0,    1, 1,  2,  32'hF0, 32'h20);
    add("fill2",       0, 0, 1, 32'hF2,32'h28,  0,    1, 1,  3,  32'hF0, 32'h20);
    add("fill3",       0, 0, 1, 32'hF3,32'h2C,  0,    1, 0,  4,  32'hF0, 32'h20);
    add("full_both",   0, 0, 1, 32'hBAD,32'h99, 1,    1, 1,  3,  32'hF1, 32'h24);
    add("drain1",      0, 0, 0, '0,    '0,      1,    1, 1,  2,  32'hF2, 32'h28);
    add("drain2",      0, 0, 0, '0,    '0,      1,    1, 1,  1,  32'hF3, 32'h2C);
    add("drain3",      0, 0, 0, '0,    '0,      1,    0, 1,  0,  '0,     '0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].in_valid, vecs[i].in_ir, vecs[i].in_pc,
            vecs[i].out_ready);
      tick();
      expect_state(vecs[i].name, vecs[i].e_out_valid, vecs[i].e_in_ready, vecs[i].e_count,
                   vecs[i].e_out_ir, vecs[i].e_out_pc);
    end

    // Steady stream at count=1; pointers wrap several times.
    drive(1'b0, 1'b0, 1'b1, 32'hA000_0000, 32'h100, 1'b0);
    tick();
    expect_state("stream_prime", 1'b1, 1'b1, 1, 32'hA000_0000, 32'h100);
    for (int k = 1; k <= 10; k++) begin
      drive(1'b0, 1'b0, 1'b1, 32'hA000_0000 + DW'(k), 32'h100 + PCW'(4 * k), 1'b1);
      tick();
      expect_state($sformatf("stream%0d", k), 1'b1, 1'b1, 1,
                   32'hA000_0000 + DW'(k), 32'h100 + PCW'(4 * k));
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    tick();
    expect_state("stream_drain", 1'b0, 1'b1, 0, '0, '0);

    // Flush at count=3 with a same-cycle push and pop.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b1, 32'hC000_0000 + DW'(k), 32'h200 + PCW'(4 * k), 1'b0);
      tick();
    end
    expect_state("pre_flush", 1'b1, 1'b1, 3, 32'hC000_0000, 32'h200);
    drive(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'h300, 1'b1);
    tick();
    expect_state("flush", 1'b0, 1'b1, 0, '0, '0);
    drive(1'b0, 1'b0, 1'b1, 32'h0C00_0040, 32'h400, 1'b0);
    tick();
    expect_state("post_flush_push", 1'b1, 1'b1, 1, 32'h0C00_0040, 32'h400);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    tick();
    expect_state("post_flush_pop", 1'b0, 1'b1, 0, '0, '0);

    // Reset together with flush and push while two entries are queued.
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b1, 32'hE000_0000 + DW'(k), 32'h500 + PCW'(4 * k), 1'b0);
      tick();
    end
    expect_state("pre_rst", 1'b1, 1'b1, 2, 32'hE000_0000, 32'h500);
    drive(1'b1, 1'b1, 1'b1, 32'h1234_5678, 32'h600, 1'b1);
    tick();
    expect_state("rst_mid", 1'b0, 1'b1, 0, '0, '0);
    drive(1'b0, 1'b0, 1'b1, 32'h8765_4321, 32'h700, 1'b0);
    tick();
    expect_state("post_rst_push", 1'b1, 1'b1, 1, 32'h8765_4321, 32'h700);
    drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    tick();
    expect_state("post_rst_pop", 1'b0, 1'b1, 0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
